// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame geometry, default timing and parity.
// Imported by ps2_line_sync and ps2_host_tx.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam int DATA_W          = 8;
    localparam int PS2_FRAME_BITS  = 11;

    // Default timing at 50 MHz
    localparam int DEF_INHIBIT_CYCLES    = 5000;
    localparam int DEF_START_HOLD_CYCLES = 50;
    localparam int DEF_TIMEOUT_CYCLES    = 750000;
    localparam int DEF_FILTER_LEN        = 8;

    function automatic logic odd_parity(input logic [DATA_W-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioner: 2-FF synchronizer, FILTER_LEN stability filter and falling-edge flag.
// Shared by the keyboard receiver and the host transmitter.
module ps2_line_sync
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_filt,
    output logic line_fall
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] stable_cnt;
    logic             filt_q;
    logic             fall_q;

    // Lines idle high, so everything resets to the released level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0    <= 1'b1;
            sync_p1    <= 1'b1;
            filt_q     <= 1'b1;
            fall_q     <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_p0 <= line_in;
            sync_p1 <= sync_p0;
            fall_q  <= 1'b0;
            if (sync_p1 == filt_q) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(FILTER_LEN - 1)) begin
                stable_cnt <= '0;
                filt_q     <= sync_p1;
                fall_q     <= filt_q & ~sync_p1;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign line_filt = filt_q;
    assign line_fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter driving open-drain clock/data enables.
// Optional macro PS2_TX_RETRY_EN: retry a NACK/timeout up to twice before reporting tx_error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES    = DEF_INHIBIT_CYCLES,
    parameter int START_HOLD_CYCLES = DEF_START_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
    parameter int FILTER_LEN        = DEF_FILTER_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              tx_done,
    output logic              tx_error,
    input  logic              ps2_clk_in,
    input  logic              ps2_dat_in,
    output logic              ps2_clk_oe,
    output logic              ps2_dat_oe
);

    localparam int PH_MAX   = (INHIBIT_CYCLES > START_HOLD_CYCLES) ? INHIBIT_CYCLES
                                                                   : START_HOLD_CYCLES;
    localparam int PH_W     = $clog2(PH_MAX + 1);
    localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LAST_IDX = PS2_FRAME_BITS - 2;

    ps2_state_e                  state_q, state_d;
    logic [PH_W-1:0]             ph_cnt_q, ph_cnt_d;
    logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
    logic [3:0]                  bit_idx_q, bit_idx_d;
    logic [DATA_W:0]             frame_q, frame_d;
    logic                        dat_oe_q, dat_oe_d;
    logic                        ack_ok_q, ack_ok_d;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]                  retry_q, retry_d;
`endif

    logic                        clk_filt, clk_fall;
    logic                        dat_filt, dat_fall_unused;
    logic                        in_frame, timeout_hit;
    logic                        fail, done_c, error_c;
    logic [PS2_FRAME_BITS-2:0]   tx_bits;

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
        .clk       (clk),
        .rst       (rst),
        .line_in   (ps2_clk_in),
        .line_filt (clk_filt),
        .line_fall (clk_fall)
    );

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_dat_sync (
        .clk       (clk),
        .rst       (rst),
        .line_in   (ps2_dat_in),
        .line_filt (dat_filt),
        .line_fall (dat_fall_unused)
    );

    // Bits shifted out after the start bit: data LSB first, parity, then stop
    assign tx_bits     = {1'b1, frame_q};
    assign in_frame    = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);
    assign timeout_hit = in_frame && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ph_cnt_q  <= '0;
            to_cnt_q  <= '0;
            bit_idx_q <= '0;
            dat_oe_q  <= 1'b0;
            ack_ok_q  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ph_cnt_q  <= ph_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_idx_q <= bit_idx_d;
            dat_oe_q  <= dat_oe_d;
            ack_ok_q  <= ack_ok_d;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    always_comb begin
        state_d   = state_q;
        ph_cnt_d  = ph_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        dat_oe_d  = dat_oe_q;
        ack_ok_d  = ack_ok_q;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        fail      = 1'b0;
        done_c    = 1'b0;
        error_c   = 1'b0;

        if (in_frame) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    frame_d  = {odd_parity(tx_data), tx_data};
                    ph_cnt_d = '0;
                    dat_oe_d = 1'b0;
                    state_d  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d  = '0;
`endif
                end
            end
            INHIBIT: begin
                if (ph_cnt_q == PH_W'(INHIBIT_CYCLES - 1)) begin
                    ph_cnt_d = '0;
                    state_d  = REQ;
                end else begin
                    ph_cnt_d = ph_cnt_q + 1'b1;
                end
            end
            REQ: begin
                // Start bit is the data line held low when the clock is released
                if (ph_cnt_q == PH_W'(START_HOLD_CYCLES - 1)) begin
                    ph_cnt_d  = '0;
                    to_cnt_d  = '0;
                    bit_idx_d = '0;
                    dat_oe_d  = 1'b1;
                    state_d   = SEND;
                end else begin
                    ph_cnt_d = ph_cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (timeout_hit) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    dat_oe_d = ~tx_bits[bit_idx_q];
                    if (bit_idx_q == 4'(LAST_IDX)) begin
                        state_d = ACK;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ACK: begin
                if (timeout_hit) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    ack_ok_d = ~dat_filt;
                    state_d  = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (timeout_hit) begin
                    fail = 1'b1;
                end else if (clk_filt && dat_filt) begin
                    if (ack_ok_q) begin
                        done_c = 1'b1;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done_c) begin
            dat_oe_d = 1'b0;
            state_d  = IDLE;
        end

        if (fail) begin
            dat_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q != 2'd2) begin
                retry_d  = retry_q + 1'b1;
                ph_cnt_d = '0;
                state_d  = INHIBIT;
            end else begin
                error_c = 1'b1;
                state_d = IDLE;
            end
`else
            error_c = 1'b1;
            state_d = IDLE;
`endif
        end
    end

    assign tx_ready   = (state_q == IDLE);
    assign busy       = ~tx_ready;
    assign tx_done    = done_c & ~rst;
    assign tx_error   = error_c & ~rst;
    assign ps2_clk_oe = (state_q == INHIBIT) || (state_q == REQ);
    // Data is released in the very cycle a timeout is reported
    assign ps2_dat_oe = (state_q == REQ) || (dat_oe_q && !timeout_hit);

endmodule
